// File: rtl/note_voice_alloc.sv
// Polyphonic voice allocator: each accepted MIDI key event scans every voice, one per clock,
// then assigns or releases one voice. Priority is retrigger, idle, released, round-robin steal.
module note_voice_alloc #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
) (
    input  logic               OSC_CLK,
    input  logic               iRST_N,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic               ev_is_on,
    input  logic [6:0]         ev_key,
    input  logic [6:0]         ev_vel,
    input  logic               all_off,
    input  logic [VOICES-1:0]  voice_free,
    output logic [VOICES-1:0]  keys_on,
    output logic               note_on,
    output logic [V_WIDTH-1:0] cur_key_adr,
    output logic [7:0]         cur_key_val,
    output logic [7:0]         cur_vel_on,
    output logic [7:0]         cur_vel_off
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        APPLY = 2'd2
    } state_t;

    localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);

    state_t               state_q, state_d;
    logic [V_WIDTH-1:0]   scanIdx_q, scanIdx_d;
    logic [6:0]           evKey_q, evKey_d;
    logic [6:0]           evVel_q, evVel_d;
    logic                 evIsOn_q, evIsOn_d;
    logic                 matchFound_q, matchFound_d;
    logic [V_WIDTH-1:0]   matchIdx_q, matchIdx_d;
    logic                 idleFound_q, idleFound_d;
    logic [V_WIDTH-1:0]   idleIdx_q, idleIdx_d;
    logic                 relFound_q, relFound_d;
    logic [V_WIDTH-1:0]   relIdx_q, relIdx_d;
    logic [VOICES-1:0]    keys_on_q, keys_on_d;
    logic [6:0]           key_tab_q [VOICES];
    logic [6:0]           key_tab_d [VOICES];
    logic [V_WIDTH-1:0]   steal_ptr_q, steal_ptr_d;
    logic                 note_on_q, note_on_d;
    logic [V_WIDTH-1:0]   cur_key_adr_q, cur_key_adr_d;
    logic [7:0]           cur_key_val_q, cur_key_val_d;
    logic [7:0]           cur_vel_on_q, cur_vel_on_d;
    logic [7:0]           cur_vel_off_q, cur_vel_off_d;

    logic                 hitMatch, hitIdle, hitRel;
    logic [V_WIDTH-1:0]   sel;

    // A panic request blocks acceptance so the event is never half-processed.
    assign ev_ready = iRST_N && (state_q == IDLE) && !all_off;

    assign keys_on     = keys_on_q;
    assign note_on     = note_on_q;
    assign cur_key_adr = cur_key_adr_q;
    assign cur_key_val = cur_key_val_q;
    assign cur_vel_on  = cur_vel_on_q;
    assign cur_vel_off = cur_vel_off_q;

    always_ff @(posedge OSC_CLK) begin
        if (!iRST_N) begin
            state_q       <= IDLE;
            scanIdx_q     <= '0;
            evKey_q       <= '0;
            evVel_q       <= '0;
            evIsOn_q      <= 1'b0;
            matchFound_q  <= 1'b0;
            matchIdx_q    <= '0;
            idleFound_q   <= 1'b0;
            idleIdx_q     <= '0;
            relFound_q    <= 1'b0;
            relIdx_q      <= '0;
            keys_on_q     <= '0;
            key_tab_q     <= '{default: '0};
            steal_ptr_q   <= '0;
            note_on_q     <= 1'b0;
            cur_key_adr_q <= '0;
            cur_key_val_q <= '0;
            cur_vel_on_q  <= '0;
            cur_vel_off_q <= '0;
        end else begin
            state_q       <= state_d;
            scanIdx_q     <= scanIdx_d;
            evKey_q       <= evKey_d;
            evVel_q       <= evVel_d;
            evIsOn_q      <= evIsOn_d;
            matchFound_q  <= matchFound_d;
            matchIdx_q    <= matchIdx_d;
            idleFound_q   <= idleFound_d;
            idleIdx_q     <= idleIdx_d;
            relFound_q    <= relFound_d;
            relIdx_q      <= relIdx_d;
            keys_on_q     <= keys_on_d;
            key_tab_q     <= key_tab_d;
            steal_ptr_q   <= steal_ptr_d;
            note_on_q     <= note_on_d;
            cur_key_adr_q <= cur_key_adr_d;
            cur_key_val_q <= cur_key_val_d;
            cur_vel_on_q  <= cur_vel_on_d;
            cur_vel_off_q <= cur_vel_off_d;
        end
    end

    // voice_free is sampled live for the voice under examination only.
    assign hitMatch = keys_on_q[scanIdx_q] && (key_tab_q[scanIdx_q] == evKey_q);
    assign hitIdle  = !keys_on_q[scanIdx_q] && voice_free[scanIdx_q];
    assign hitRel   = !keys_on_q[scanIdx_q];

    always_comb begin
        state_d       = state_q;
        scanIdx_d     = scanIdx_q;
        evKey_d       = evKey_q;
        evVel_d       = evVel_q;
        evIsOn_d      = evIsOn_q;
        matchFound_d  = matchFound_q;
        matchIdx_d    = matchIdx_q;
        idleFound_d   = idleFound_q;
        idleIdx_d     = idleIdx_q;
        relFound_d    = relFound_q;
        relIdx_d      = relIdx_q;
        keys_on_d     = keys_on_q;
        key_tab_d     = key_tab_q;
        steal_ptr_d   = steal_ptr_q;
        note_on_d     = 1'b0;
        cur_key_adr_d = cur_key_adr_q;
        cur_key_val_d = cur_key_val_q;
        cur_vel_on_d  = cur_vel_on_q;
        cur_vel_off_d = cur_vel_off_q;
        sel           = '0;

        case (state_q)
            IDLE: begin
                if (ev_valid && ev_ready) begin
                    evKey_d      = ev_key;
                    evVel_d      = ev_vel;
                    evIsOn_d     = ev_is_on;
                    scanIdx_d    = '0;
                    matchFound_d = 1'b0;
                    idleFound_d  = 1'b0;
                    relFound_d   = 1'b0;
                    state_d      = SCAN;
                end
            end

            SCAN: begin
                if (!matchFound_q && hitMatch) begin
                    matchFound_d = 1'b1;
                    matchIdx_d   = scanIdx_q;
                end
                if (!idleFound_q && hitIdle) begin
                    idleFound_d = 1'b1;
                    idleIdx_d   = scanIdx_q;
                end
                if (!relFound_q && hitRel) begin
                    relFound_d = 1'b1;
                    relIdx_d   = scanIdx_q;
                end
                scanIdx_d = scanIdx_q + V_WIDTH'(1);

                // The decision folds in the last voice combinationally so results appear in APPLY.
                if (scanIdx_q == LAST_IDX) begin
                    state_d   = APPLY;
                    scanIdx_d = '0;
                    if (evIsOn_q && (evVel_q != 7'd0)) begin
                        if (matchFound_d) begin
                            sel = matchIdx_d;
                        end else if (idleFound_d) begin
                            sel = idleIdx_d;
                        end else if (relFound_d) begin
                            sel = relIdx_d;
                        end else begin
                            sel         = steal_ptr_q;
                            steal_ptr_d = (steal_ptr_q == LAST_IDX) ? '0 : steal_ptr_q + V_WIDTH'(1);
                        end
                        keys_on_d[sel] = 1'b1;
                        key_tab_d[sel] = evKey_q;
                        cur_key_adr_d  = sel;
                        cur_key_val_d  = {1'b0, evKey_q};
                        cur_vel_on_d   = {1'b0, evVel_q};
                        note_on_d      = 1'b1;
                    end else if (matchFound_d) begin
                        keys_on_d[matchIdx_d] = 1'b0;
                        cur_key_adr_d         = matchIdx_d;
                        cur_key_val_d         = {1'b0, evKey_q};
                        cur_vel_off_d         = {1'b0, evVel_q};
                    end
                end
            end

            APPLY: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Panic wins over everything, including an allocation decided this very cycle.
        if (all_off) begin
            state_d       = IDLE;
            scanIdx_d     = '0;
            keys_on_d     = '0;
            key_tab_d     = key_tab_q;
            steal_ptr_d   = steal_ptr_q;
            note_on_d     = 1'b0;
            cur_key_adr_d = cur_key_adr_q;
            cur_key_val_d = cur_key_val_q;
            cur_vel_on_d  = cur_vel_on_q;
            cur_vel_off_d = cur_vel_off_q;
        end
    end

endmodule

// File: tb/tb_note_voice_alloc.sv
// Bench for note_voice_alloc: directed scenarios plus randomized key events checked
// against a voice-table model computed directly from the allocation rules.
module tb_note_voice_alloc;

    logic       OSC_CLK = 1'b0;
    logic       iRST_N;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_is_on;
    logic [6:0] ev_key;
    logic [6:0] ev_vel;
    logic       all_off;
    logic [7:0] voice_free;
    logic [7:0] keys_on;
    logic       note_on;
    logic [2:0] cur_key_adr;
    logic [7:0] cur_key_val;
    logic [7:0] cur_vel_on;
    logic [7:0] cur_vel_off;

    int total = 0;
    int bad   = 0;

    // Observations collected by the event driver
    logic rdyOffer, pulse9, pulseOther, rdy10;

    // Reference model state
    logic [7:0] mKeys;
    logic [6:0] mTab [8];
    int         mSteal;
    logic [2:0] mAdr;
    logic [7:0] mKeyVal, mVelOn, mVelOff;
    logic       mPulse;

    always #5 OSC_CLK = ~OSC_CLK;

    note_voice_alloc #(.VOICES(8), .V_WIDTH(3)) dut (
        .OSC_CLK     (OSC_CLK),
        .iRST_N      (iRST_N),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_is_on    (ev_is_on),
        .ev_key      (ev_key),
        .ev_vel      (ev_vel),
        .all_off     (all_off),
        .voice_free  (voice_free),
        .keys_on     (keys_on),
        .note_on     (note_on),
        .cur_key_adr (cur_key_adr),
        .cur_key_val (cur_key_val),
        .cur_vel_on  (cur_vel_on),
        .cur_vel_off (cur_vel_off)
    );

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        mKeys   = 8'h00;
        for (int v = 0; v < 8; v++) mTab[v] = 7'd0;
        mSteal  = 0;
        mAdr    = 3'd0;
        mKeyVal = 8'd0;
        mVelOn  = 8'd0;
        mVelOff = 8'd0;
        mPulse  = 1'b0;
    endtask

    task automatic modelEvent(input logic isOn, input logic [6:0] key, input logic [6:0] vel,
                              input logic [7:0] vf);
        int match = -1;
        int idle  = -1;
        int rel   = -1;
        int sel;
        for (int v = 0; v < 8; v++) begin
            if (match < 0 && mKeys[v] && mTab[v] == key) match = v;
            if (idle < 0 && !mKeys[v] && vf[v]) idle = v;
            if (rel < 0 && !mKeys[v]) rel = v;
        end
        mPulse = 1'b0;
        if (isOn && vel != 7'd0) begin
            if (match >= 0)     sel = match;
            else if (idle >= 0) sel = idle;
            else if (rel >= 0)  sel = rel;
            else begin
                sel    = mSteal;
                mSteal = (mSteal + 1) % 8;
            end
            mKeys[sel] = 1'b1;
            mTab[sel]  = key;
            mAdr       = sel[2:0];
            mKeyVal    = {1'b0, key};
            mVelOn     = {1'b0, vel};
            mPulse     = 1'b1;
        end else if (match >= 0) begin
            mKeys[match] = 1'b0;
            mAdr         = match[2:0];
            mKeyVal      = {1'b0, key};
            mVelOff      = {1'b0, vel};
        end
    endtask

    task automatic applyReset();
        iRST_N   = 1'b0;
        ev_valid = 1'b0;
        all_off  = 1'b0;
        repeat (2) @(negedge OSC_CLK);
        iRST_N = 1'b1;
        modelReset();
    endtask

    // Offers one event at a negedge and observes cycles T+1..T+10; returns at negedge of T+10.
    task automatic doEvent(input logic isOn, input logic [6:0] key, input logic [6:0] vel,
                           input logic [7:0] vf, input int changeAt, input logic [7:0] vfAfter);
        voice_free = vf;
        ev_is_on   = isOn;
        ev_key     = key;
        ev_vel     = vel;
        ev_valid   = 1'b1;
        #1;
        rdyOffer = ev_ready;
        @(posedge OSC_CLK);
        @(negedge OSC_CLK);
        ev_valid   = 1'b0;
        pulse9     = 1'b0;
        pulseOther = 1'b0;
        rdy10      = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == changeAt) voice_free = vfAfter;
            if (c == 9) pulse9 = note_on;
            else        pulseOther = pulseOther | note_on;
            if (c == 10) rdy10 = ev_ready;
            else         @(negedge OSC_CLK);
        end
    endtask

    task automatic test_reset();
        iRST_N   = 1'b0;
        ev_valid = 1'b1;
        all_off  = 1'b0;
        @(negedge OSC_CLK);
        total++; if (ev_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready_low: got %b want 0", ev_ready); end
        ev_valid = 1'b0;
        @(negedge OSC_CLK);
        iRST_N = 1'b1;
        @(negedge OSC_CLK);
        total++; if (ev_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready_after: got %b want 1", ev_ready); end
        total++; if (keys_on !== 8'h00) begin bad++; $display("[TB] FAIL reset_keys_on: got %h want 00", keys_on); end
        total++; if (note_on !== 1'b0) begin bad++; $display("[TB] FAIL reset_note_on: got %b want 0", note_on); end
        total++; if (cur_key_adr !== 3'd0) begin bad++; $display("[TB] FAIL reset_adr: got %0d want 0", cur_key_adr); end
        total++; if ({cur_key_val, cur_vel_on, cur_vel_off} !== 24'd0) begin bad++; $display("[TB] FAIL reset_cur: got %h want 000000", {cur_key_val, cur_vel_on, cur_vel_off}); end
        modelReset();
    endtask

    task automatic test_basic();
        applyReset();
        doEvent(1'b1, 7'd60, 7'd100, 8'hFF, 0, 8'h00);
        total++; if (rdyOffer !== 1'b1) begin bad++; $display("[TB] FAIL basic_accept: got %b want 1", rdyOffer); end
        total++; if (pulse9 !== 1'b1) begin bad++; $display("[TB] FAIL basic_pulse_t9: got %b want 1", pulse9); end
        total++; if (pulseOther !== 1'b0) begin bad++; $display("[TB] FAIL basic_pulse_other: got %b want 0", pulseOther); end
        total++; if (cur_key_adr !== 3'd0) begin bad++; $display("[TB] FAIL basic_adr: got %0d want 0", cur_key_adr); end
        total++; if (keys_on !== 8'h01) begin bad++; $display("[TB] FAIL basic_keys: got %h want 01", keys_on); end
        total++; if (cur_key_val !== 8'd60) begin bad++; $display("[TB] FAIL basic_key_val: got %0d want 60", cur_key_val); end
        total++; if (cur_vel_on !== 8'd100) begin bad++; $display("[TB] FAIL basic_vel_on: got %0d want 100", cur_vel_on); end
        total++; if (rdy10 !== 1'b1) begin bad++; $display("[TB] FAIL basic_ready_t10: got %b want 1", rdy10); end
    endtask

    task automatic test_note_off();
        doEvent(1'b1, 7'd62, 7'd80, 8'hFF, 0, 8'h00);
        total++; if (keys_on !== 8'h03) begin bad++; $display("[TB] FAIL off_setup_keys: got %h want 03", keys_on); end
        doEvent(1'b0, 7'd60, 7'd40, 8'hFF, 0, 8'h00);
        total++; if (keys_on !== 8'h02) begin bad++; $display("[TB] FAIL off_keys: got %h want 02", keys_on); end
        total++; if (cur_key_adr !== 3'd0) begin bad++; $display("[TB] FAIL off_adr: got %0d want 0", cur_key_adr); end
        total++; if (cur_vel_off !== 8'd40) begin bad++; $display("[TB] FAIL off_vel_off: got %0d want 40", cur_vel_off); end
        total++; if (cur_key_val !== 8'd60) begin bad++; $display("[TB] FAIL off_key_val: got %0d want 60", cur_key_val); end
        total++; if (cur_vel_on !== 8'd80) begin bad++; $display("[TB] FAIL off_vel_on_kept: got %0d want 80", cur_vel_on); end
        total++; if ((pulse9 | pulseOther) !== 1'b0) begin bad++; $display("[TB] FAIL off_no_pulse: got %b want 0", pulse9 | pulseOther); end
        doEvent(1'b0, 7'd99, 7'd11, 8'hFF, 0, 8'h00);
        total++; if ({keys_on, cur_key_val, cur_vel_off} !== {8'h02, 8'd60, 8'd40}) begin bad++; $display("[TB] FAIL off_nomatch_state: got %h want 023c28", {keys_on, cur_key_val, cur_vel_off}); end
    endtask

    task automatic test_steal();
        applyReset();
        for (int i = 0; i < 8; i++) doEvent(1'b1, 7'(40 + i), 7'd64, 8'hFF, 0, 8'h00);
        total++; if (keys_on !== 8'hFF) begin bad++; $display("[TB] FAIL steal_fill: got %h want ff", keys_on); end
        doEvent(1'b1, 7'd72, 7'd99, 8'hFF, 0, 8'h00);
        total++; if (cur_key_adr !== 3'd0) begin bad++; $display("[TB] FAIL steal_first_adr: got %0d want 0", cur_key_adr); end
        total++; if (pulse9 !== 1'b1) begin bad++; $display("[TB] FAIL steal_first_pulse: got %b want 1", pulse9); end
        doEvent(1'b1, 7'd73, 7'd99, 8'h00, 0, 8'h00);
        total++; if (cur_key_adr !== 3'd1) begin bad++; $display("[TB] FAIL steal_second_adr: got %0d want 1", cur_key_adr); end
        doEvent(1'b0, 7'd72, 7'd5, 8'h00, 0, 8'h00);
        total++; if (keys_on !== 8'hFE) begin bad++; $display("[TB] FAIL steal_tab_key72: got %h want fe", keys_on); end
        total++; if (cur_vel_off !== 8'd5) begin bad++; $display("[TB] FAIL steal_vel_off: got %0d want 5", cur_vel_off); end
    endtask

    task automatic test_vel_zero();
        applyReset();
        doEvent(1'b1, 7'd60, 7'd50, 8'hFF, 0, 8'h00);
        doEvent(1'b1, 7'd61, 7'd20, 8'hFF, 0, 8'h00);
        doEvent(1'b0, 7'd61, 7'd33, 8'hFF, 0, 8'h00);
        total++; if (cur_vel_off !== 8'd33) begin bad++; $display("[TB] FAIL vz_setup_vel_off: got %0d want 33", cur_vel_off); end
        doEvent(1'b1, 7'd60, 7'd0, 8'hFF, 0, 8'h00);
        total++; if (keys_on !== 8'h00) begin bad++; $display("[TB] FAIL vz_keys: got %h want 00", keys_on); end
        total++; if ((pulse9 | pulseOther) !== 1'b0) begin bad++; $display("[TB] FAIL vz_no_pulse: got %b want 0", pulse9 | pulseOther); end
        total++; if (cur_vel_off !== 8'd0) begin bad++; $display("[TB] FAIL vz_vel_off: got %0d want 0", cur_vel_off); end
        total++; if (cur_vel_on !== 8'd20) begin bad++; $display("[TB] FAIL vz_vel_on_kept: got %0d want 20", cur_vel_on); end
        doEvent(1'b1, 7'd60, 7'd90, 8'hFF, 0, 8'h00);
        doEvent(1'b1, 7'd60, 7'd90, 8'h00, 0, 8'h00);
        total++; if (cur_key_adr !== 3'd0) begin bad++; $display("[TB] FAIL vz_retrig_adr: got %0d want 0", cur_key_adr); end
        total++; if (pulse9 !== 1'b1) begin bad++; $display("[TB] FAIL vz_retrig_pulse: got %b want 1", pulse9); end
        total++; if (keys_on !== 8'h01) begin bad++; $display("[TB] FAIL vz_retrig_keys: got %h want 01", keys_on); end
    endtask

    task automatic test_idle_priority();
        applyReset();
        doEvent(1'b1, 7'd10, 7'd30, 8'hFF, 0, 8'h00);
        doEvent(1'b1, 7'd11, 7'd30, 8'hFF, 0, 8'h00);
        doEvent(1'b0, 7'd10, 7'd30, 8'hFF, 0, 8'h00);
        doEvent(1'b0, 7'd11, 7'd30, 8'hFF, 0, 8'h00);
        doEvent(1'b1, 7'd20, 7'd30, 8'hFE, 0, 8'h00);
        total++; if (cur_key_adr !== 3'd1) begin bad++; $display("[TB] FAIL prio_idle_adr: got %0d want 1", cur_key_adr); end
        doEvent(1'b1, 7'd21, 7'd30, 8'h00, 0, 8'h00);
        total++; if (cur_key_adr !== 3'd0) begin bad++; $display("[TB] FAIL prio_released_adr: got %0d want 0", cur_key_adr); end
        total++; if (keys_on !== 8'h03) begin bad++; $display("[TB] FAIL prio_keys: got %h want 03", keys_on); end
    endtask

    task automatic test_live_free();
        applyReset();
        doEvent(1'b1, 7'd70, 7'd10, 8'h20, 7, 8'h00);
        total++; if (cur_key_adr !== 3'd5) begin bad++; $display("[TB] FAIL live_free_adr: got %0d want 5", cur_key_adr); end
        total++; if (keys_on !== 8'h20) begin bad++; $display("[TB] FAIL live_free_keys: got %h want 20", keys_on); end
    endtask

    task automatic test_all_off();
        logic seen;
        applyReset();
        doEvent(1'b1, 7'd50, 7'd60, 8'hFF, 0, 8'h00);
        doEvent(1'b1, 7'd51, 7'd60, 8'hFF, 0, 8'h00);
        ev_is_on = 1'b1; ev_key = 7'd52; ev_vel = 7'd70; ev_valid = 1'b1;
        @(posedge OSC_CLK);
        @(negedge OSC_CLK);
        ev_valid = 1'b0;
        repeat (3) @(negedge OSC_CLK);
        all_off = 1'b1;
        @(negedge OSC_CLK);
        all_off = 1'b0;
        #1;
        total++; if (keys_on !== 8'h00) begin bad++; $display("[TB] FAIL alloff_keys: got %h want 00", keys_on); end
        total++; if (ev_ready !== 1'b1) begin bad++; $display("[TB] FAIL alloff_ready: got %b want 1", ev_ready); end
        seen = note_on;
        repeat (10) begin @(negedge OSC_CLK); seen = seen | note_on; end
        total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL alloff_no_pulse: got %b want 0", seen); end
        ev_key = 7'd53; ev_valid = 1'b1; all_off = 1'b1;
        #1;
        total++; if (ev_ready !== 1'b0) begin bad++; $display("[TB] FAIL alloff_coincide_ready: got %b want 0", ev_ready); end
        @(posedge OSC_CLK);
        @(negedge OSC_CLK);
        ev_valid = 1'b0; all_off = 1'b0;
        seen = 1'b0;
        repeat (12) begin @(negedge OSC_CLK); seen = seen | note_on; end
        total++; if ({seen, keys_on} !== 9'h000) begin bad++; $display("[TB] FAIL alloff_coincide_ignored: got %h want 000", {seen, keys_on}); end
        total++; if (cur_key_val !== 8'd51) begin bad++; $display("[TB] FAIL alloff_cur_kept: got %0d want 51", cur_key_val); end
    endtask

    task automatic test_reset_mid_scan();
        logic seen;
        applyReset();
        doEvent(1'b1, 7'd30, 7'd44, 8'hFF, 0, 8'h00);
        ev_is_on = 1'b1; ev_key = 7'd31; ev_vel = 7'd45; ev_valid = 1'b1;
        @(posedge OSC_CLK);
        @(negedge OSC_CLK);
        ev_valid = 1'b0;
        repeat (2) @(negedge OSC_CLK);
        iRST_N = 1'b0;
        @(negedge OSC_CLK);
        iRST_N = 1'b1;
        #1;
        total++; if (ev_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_ready: got %b want 1", ev_ready); end
        total++; if ({keys_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off} !== 35'd0) begin bad++; $display("[TB] FAIL rstmid_outputs: got %h want 0", {keys_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off}); end
        seen = note_on;
        repeat (10) begin @(negedge OSC_CLK); seen = seen | note_on; end
        total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_no_pulse: got %b want 0", seen); end
        modelReset();
        doEvent(1'b1, 7'd90, 7'd1, 8'h00, 0, 8'h00);
        total++; if (cur_key_adr !== 3'd0) begin bad++; $display("[TB] FAIL rstmid_after_adr: got %0d want 0", cur_key_adr); end
    endtask

    task automatic test_random();
        logic       isOn;
        logic [6:0] key, vel;
        logic [7:0] vf;
        applyReset();
        for (int n = 0; n < 80; n++) begin
            isOn = ($urandom_range(0, 99) < 65);
            key  = 7'($urandom_range(40, 51));
            vel  = ($urandom_range(0, 6) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            vf   = 8'($urandom);
            modelEvent(isOn, key, vel, vf);
            doEvent(isOn, key, vel, vf, 0, 8'h00);
            total++; if (rdyOffer !== 1'b1) begin bad++; $display("[TB] FAIL rand_accept[%0d]: got %b want 1", n, rdyOffer); end
            total++; if (pulse9 !== mPulse) begin bad++; $display("[TB] FAIL rand_pulse[%0d]: got %b want %b", n, pulse9, mPulse); end
            total++; if (pulseOther !== 1'b0) begin bad++; $display("[TB] FAIL rand_stray_pulse[%0d]: got %b want 0", n, pulseOther); end
            total++; if (rdy10 !== 1'b1) begin bad++; $display("[TB] FAIL rand_ready_t10[%0d]: got %b want 1", n, rdy10); end
            total++; if (keys_on !== mKeys) begin bad++; $display("[TB] FAIL rand_keys[%0d]: got %h want %h", n, keys_on, mKeys); end
            total++; if (cur_key_adr !== mAdr) begin bad++; $display("[TB] FAIL rand_adr[%0d]: got %0d want %0d", n, cur_key_adr, mAdr); end
            total++; if (cur_key_val !== mKeyVal) begin bad++; $display("[TB] FAIL rand_key_val[%0d]: got %0d want %0d", n, cur_key_val, mKeyVal); end
            total++; if (cur_vel_on !== mVelOn) begin bad++; $display("[TB] FAIL rand_vel_on[%0d]: got %0d want %0d", n, cur_vel_on, mVelOn); end
            total++; if (cur_vel_off !== mVelOff) begin bad++; $display("[TB] FAIL rand_vel_off[%0d]: got %0d want %0d", n, cur_vel_off, mVelOff); end
        end
    endtask

    initial begin
        iRST_N     = 1'b0;
        ev_valid   = 1'b0;
        ev_is_on   = 1'b0;
        ev_key     = 7'd0;
        ev_vel     = 7'd0;
        all_off    = 1'b0;
        voice_free = 8'hFF;
        modelReset();
        @(negedge OSC_CLK);
        test_reset();
        test_basic();
        test_note_off();
        test_steal();
        test_vel_zero();
        test_idle_priority();
        test_live_free();
        test_all_off();
        test_reset_mid_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
